// File: rtl/irig_frame_sequencer.sv
// rtl/irig_frame_sequencer.sv - IRIG-B frame sync, position tracking and per-bit field strobes
// Define IRIG_CTRL_BITS_EN to capture the 18 control-function bits into ctrl_bits.
module irig_frame_sequencer #(
  parameter int TIMEOUT_CYCLES = 2_000_000,
  parameter int FRAME_LEN      = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sym_valid,
  input  logic [1:0]  sym_type,
  output logic [4:0]  ts_select,
  output logic        ts_reset,
  output logic [2:0]  bit_idx,
  output logic [1:0]  digit_idx,
  output logic        bit_value,
  output logic        frame_done,
  output logic        locked,
  output logic        sync_err
`ifdef IRIG_CTRL_BITS_EN
  ,
  output logic [17:0] ctrl_bits
`endif
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [6:0]    POS_LAST = 7'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    HUNT     = 2'd0,
    ONE_MARK = 2'd1,
    LOCKED   = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [6:0]      pos_q, pos_d;
  logic [3:0]      ones_q, ones_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            locked_q, locked_d;
  logic            ts_reset_q, ts_reset_d;
  logic            frame_done_q, frame_done_d;
  logic            sync_err_q, sync_err_d;
  logic [4:0]      sel_q, sel_d;
  logic [1:0]      digit_q, digit_d;
  logic [2:0]      bitn_q, bitn_d;
  logic            value_q, value_d;
`ifdef IRIG_CTRL_BITS_EN
  logic [17:0]     ctrl_sh_q, ctrl_sh_d;
  logic [17:0]     ctrl_q, ctrl_d;
`endif

  logic [6:0]      cur_pos;
  logic [3:0]      cur_ones;
  logic [9:0]      fmap;
  logic            is_marker;
  logic            is_data;
  logic            slot_ok;

  // Returns {ts_select, digit_idx, bit_idx} for a data position.
  function automatic logic [9:0] field_map(input logic [6:0] p);
    logic [9:0] r;
    r = '0;
    if      (p >= 7'd1  && p <= 7'd4 ) r = {5'd1, 2'd0, 3'(p - 7'd1)};
    else if (p >= 7'd6  && p <= 7'd8 ) r = {5'd1, 2'd1, 3'(p - 7'd6)};
    else if (p >= 7'd10 && p <= 7'd13) r = {5'd2, 2'd0, 3'(p - 7'd10)};
    else if (p >= 7'd15 && p <= 7'd17) r = {5'd2, 2'd1, 3'(p - 7'd15)};
    else if (p >= 7'd20 && p <= 7'd23) r = {5'd3, 2'd0, 3'(p - 7'd20)};
    else if (p >= 7'd25 && p <= 7'd26) r = {5'd3, 2'd1, 3'(p - 7'd25)};
    else if (p >= 7'd30 && p <= 7'd33) r = {5'd4, 2'd0, 3'(p - 7'd30)};
    else if (p >= 7'd35 && p <= 7'd38) r = {5'd4, 2'd1, 3'(p - 7'd35)};
    else if (p >= 7'd40 && p <= 7'd41) r = {5'd4, 2'd2, 3'(p - 7'd40)};
    else if (p >= 7'd50 && p <= 7'd53) r = {5'd5, 2'd0, 3'(p - 7'd50)};
    else if (p >= 7'd55 && p <= 7'd58) r = {5'd5, 2'd1, 3'(p - 7'd55)};
    else if (p >= 7'd80 && p <= 7'd88) r = {5'd6, 5'(p - 7'd80)};
    else if (p >= 7'd90 && p <= 7'd97) r = {5'd6, 5'(p - 7'd81)};
    return r;
  endfunction

  // ones_q tracks pos mod 10 so marker slots need no divider.
  assign cur_pos   = pos_q + 7'd1;
  assign cur_ones  = (ones_q == 4'd9) ? 4'd0 : ones_q + 4'd1;
  assign fmap      = field_map(cur_pos);
  assign is_marker = (sym_type == 2'b10);
  assign is_data   = ~sym_type[1];
  assign slot_ok   = (cur_ones == 4'd9) ? is_marker : is_data;

  always_comb begin
    state_d      = state_q;
    pos_d        = pos_q;
    ones_d       = ones_q;
    cnt_d        = cnt_q;
    locked_d     = locked_q;
    ts_reset_d   = 1'b0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    sel_d        = '0;
    digit_d      = '0;
    bitn_d       = '0;
    value_d      = 1'b0;
`ifdef IRIG_CTRL_BITS_EN
    ctrl_sh_d    = ctrl_sh_q;
    ctrl_d       = ctrl_q;
`endif

    if (state_q == HUNT || sym_valid || cnt_q == CNT_LAST) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (sym_valid) begin
      case (state_q)
        HUNT: begin
          if (is_marker) state_d = ONE_MARK;
        end
        ONE_MARK: begin
          if (is_marker) begin
            state_d    = LOCKED;
            pos_d      = '0;
            ones_d     = '0;
            ts_reset_d = 1'b1;
            locked_d   = 1'b1;
          end else begin
            state_d    = HUNT;
            sync_err_d = locked_q;
            locked_d   = 1'b0;
          end
        end
        LOCKED: begin
          if (!slot_ok) begin
            state_d    = HUNT;
            sync_err_d = 1'b1;
            locked_d   = 1'b0;
          end else if (cur_pos == POS_LAST) begin
            state_d      = ONE_MARK;
            frame_done_d = 1'b1;
`ifdef IRIG_CTRL_BITS_EN
            ctrl_d       = ctrl_sh_q;
`endif
          end else begin
            pos_d                    = cur_pos;
            ones_d                   = cur_ones;
            {sel_d, digit_d, bitn_d} = fmap;
            value_d                  = (fmap[9:5] != 5'd0) & sym_type[0];
`ifdef IRIG_CTRL_BITS_EN
            if ((cur_pos >= 7'd60 && cur_pos <= 7'd68) ||
                (cur_pos >= 7'd70 && cur_pos <= 7'd78)) begin
              ctrl_sh_d = {sym_type[0], ctrl_sh_q[17:1]};
            end
`endif
          end
        end
        default: state_d = HUNT;
      endcase
    end else if (state_q != HUNT && cnt_q == CNT_LAST) begin
      state_d    = HUNT;
      sync_err_d = 1'b1;
      locked_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= HUNT;
      pos_q        <= '0;
      ones_q       <= '0;
      cnt_q        <= '0;
      locked_q     <= 1'b0;
      ts_reset_q   <= 1'b0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      sel_q        <= '0;
      digit_q      <= '0;
      bitn_q       <= '0;
      value_q      <= 1'b0;
`ifdef IRIG_CTRL_BITS_EN
      ctrl_sh_q    <= '0;
      ctrl_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pos_q        <= pos_d;
      ones_q       <= ones_d;
      cnt_q        <= cnt_d;
      locked_q     <= locked_d;
      ts_reset_q   <= ts_reset_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      sel_q        <= sel_d;
      digit_q      <= digit_d;
      bitn_q       <= bitn_d;
      value_q      <= value_d;
`ifdef IRIG_CTRL_BITS_EN
      ctrl_sh_q    <= ctrl_sh_d;
      ctrl_q       <= ctrl_d;
`endif
    end
  end

  assign ts_select  = sel_q;
  assign ts_reset   = ts_reset_q;
  assign bit_idx    = bitn_q;
  assign digit_idx  = digit_q;
  assign bit_value  = value_q;
  assign frame_done = frame_done_q;
  assign locked     = locked_q;
  assign sync_err   = sync_err_q;
`ifdef IRIG_CTRL_BITS_EN
  assign ctrl_bits  = ctrl_q;
`endif

endmodule

// File: tb/tb_irig_frame_sequencer.sv
// tb/tb_irig_frame_sequencer.sv - directed frame-vector bench for irig_frame_sequencer
module tb_irig_frame_sequencer;

  localparam int T = 40;
  localparam int CTRL_PAT = 'h2AAAA;
  localparam logic [1:0] S_ZERO = 2'b00, S_ONE = 2'b01, S_MARK = 2'b10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sym_valid = 1'b0;
  logic [1:0]  sym_type = 2'b00;
  logic [4:0]  ts_select;
  logic        ts_reset;
  logic [2:0]  bit_idx;
  logic [1:0]  digit_idx;
  logic        bit_value;
  logic        frame_done;
  logic        locked;
  logic        sync_err;
`ifdef IRIG_CTRL_BITS_EN
  logic [17:0] ctrl_bits;
`endif

  always #5 clk = ~clk;

  irig_frame_sequencer #(.TIMEOUT_CYCLES(T), .FRAME_LEN(100)) dut (
    .clk(clk), .rst(rst), .sym_valid(sym_valid), .sym_type(sym_type),
    .ts_select(ts_select), .ts_reset(ts_reset), .bit_idx(bit_idx),
    .digit_idx(digit_idx), .bit_value(bit_value), .frame_done(frame_done),
    .locked(locked), .sync_err(sync_err)
`ifdef IRIG_CTRL_BITS_EN
    , .ctrl_bits(ctrl_bits)
`endif
  );

  typedef struct {
    logic [1:0] sym;
    logic [4:0] sel;
    logic [1:0] dig;
    logic [2:0] bitn;
    logic       val;
  } vec_t;

  typedef struct {
    int lo;
    int hi;
    int sel;
    int dig;
    int nbase;
  } rng_t;

  vec_t vec[100];
  rng_t rng[13];
  int   fval[7];
  int   acc[7];
  int   n_chk = 0, n_fail = 0, n_reset = 0, n_done = 0, n_err = 0;
  bit   lock_watch = 1'b0, lock_drop = 1'b0;

  function automatic int pow10(input int d);
    return (d == 0) ? 1 : (d == 1) ? 10 : 100;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive, let the edge pass, then fold outputs into the pulse counters and accumulator model.
  task automatic step(input logic v, input logic [1:0] t);
    sym_valid = v;
    sym_type  = t;
    @(posedge clk);
    #1;
    sym_valid = 1'b0;
    sym_type  = S_ZERO;
    if (ts_reset === 1'b1) begin
      n_reset++;
      for (int i = 0; i < 7; i++) acc[i] = 0;
    end
    if (frame_done === 1'b1) n_done++;
    if (sync_err === 1'b1) n_err++;
    if (ts_select == 5'd6)
      acc[6] += int'(bit_value) << {digit_idx, bit_idx};
    else if (ts_select >= 5'd1 && ts_select <= 5'd5)
      acc[ts_select] += int'(bit_value) * (1 << bit_idx) * pow10(int'(digit_idx));
    if (lock_watch && locked !== 1'b1) lock_drop = 1'b1;
  endtask

  task automatic run_frame(input int lo, input int hi, input bit hunt);
    for (int p = lo; p <= hi; p++) begin
      step(1'b1, vec[p].sym);
      if (hunt) begin
        chk($sformatf("hunt_sel[%0d]", p), ts_select, 0);
        chk($sformatf("hunt_done[%0d]", p), frame_done, 0);
        chk($sformatf("hunt_err[%0d]", p), sync_err, 0);
      end else begin
        chk($sformatf("sel[%0d]", p), ts_select, vec[p].sel);
        if (vec[p].sel != 5'd0) begin
          chk($sformatf("digit[%0d]", p), digit_idx, vec[p].dig);
          chk($sformatf("bit_idx[%0d]", p), bit_idx, vec[p].bitn);
          chk($sformatf("bit_value[%0d]", p), bit_value, vec[p].val);
        end
        chk($sformatf("ts_reset[%0d]", p), ts_reset, (p == 0));
        chk($sformatf("frame_done[%0d]", p), frame_done, (p == 99));
        chk($sformatf("sync_err[%0d]", p), sync_err, 0);
        chk($sformatf("locked[%0d]", p), locked, 1);
      end
      step(1'b0, S_ZERO);
      chk($sformatf("idle_pulses[%0d]", p), {ts_select, ts_reset, frame_done, sync_err}, 0);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ts_select"}, ts_select, 0);
    chk({tag, "_ts_reset"}, ts_reset, 0);
    chk({tag, "_bit_idx"}, bit_idx, 0);
    chk({tag, "_digit_idx"}, digit_idx, 0);
    chk({tag, "_bit_value"}, bit_value, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_sync_err"}, sync_err, 0);
`ifdef IRIG_CTRL_BITS_EN
    chk({tag, "_ctrl_bits"}, ctrl_bits, 0);
`endif
  endtask

  task automatic chk_time(input string tag);
    chk({tag, "_sec"}, acc[1], 56);
    chk({tag, "_min"}, acc[2], 34);
    chk({tag, "_hour"}, acc[3], 12);
    chk({tag, "_day"}, acc[4], 123);
    chk({tag, "_year"}, acc[5], 24);
    chk({tag, "_sbs"}, acc[6], 45296);
  endtask

  initial begin
    fval = '{0, 56, 34, 12, 123, 24, 45296};
    rng[0]  = '{1, 4, 1, 0, 0};    rng[1]  = '{6, 8, 1, 1, 0};
    rng[2]  = '{10, 13, 2, 0, 0};  rng[3]  = '{15, 17, 2, 1, 0};
    rng[4]  = '{20, 23, 3, 0, 0};  rng[5]  = '{25, 26, 3, 1, 0};
    rng[6]  = '{30, 33, 4, 0, 0};  rng[7]  = '{35, 38, 4, 1, 0};
    rng[8]  = '{40, 41, 4, 2, 0};  rng[9]  = '{50, 53, 5, 0, 0};
    rng[10] = '{55, 58, 5, 1, 0};  rng[11] = '{80, 88, 6, 0, 0};
    rng[12] = '{90, 97, 6, 0, 9};
    for (int p = 0; p < 100; p++) begin
      vec[p] = '{S_ZERO, 5'd0, 2'd0, 3'd0, 1'b0};
      if (p == 0 || p % 10 == 9) vec[p].sym = S_MARK;
      else if (p >= 60 && p <= 68) vec[p].sym = ((CTRL_PAT >> (p - 60)) & 1) != 0 ? S_ONE : S_ZERO;
      else if (p >= 70 && p <= 78) vec[p].sym = ((CTRL_PAT >> (p - 61)) & 1) != 0 ? S_ONE : S_ZERO;
    end
    for (int r = 0; r < 13; r++) begin
      for (int p = rng[r].lo; p <= rng[r].hi; p++) begin
        int n;
        int v;
        if (rng[r].sel == 6) begin
          n = rng[r].nbase + p - rng[r].lo;
          v = (fval[6] >> n) & 1;
          vec[p].dig  = 2'(n >> 3);
          vec[p].bitn = 3'(n & 7);
        end else begin
          n = p - rng[r].lo;
          v = (((fval[rng[r].sel] / pow10(rng[r].dig)) % 10) >> n) & 1;
          vec[p].dig  = 2'(rng[r].dig);
          vec[p].bitn = 3'(n);
        end
        vec[p].sel = 5'(rng[r].sel);
        vec[p].val = (v != 0);
        vec[p].sym = (v != 0) ? S_ONE : S_ZERO;
      end
    end

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;

    // Frame 1: leading marker, then Pr and a full frame
    step(1'b1, S_MARK);
    chk("first_mark_locked", locked, 0);
    chk("first_mark_ts_reset", ts_reset, 0);
    step(1'b0, S_ZERO);
    run_frame(0, 99, 1'b0);
    chk_time("frame1");
    chk("frame1_resets", n_reset, 1);
    chk("frame1_done", n_done, 1);
`ifdef IRIG_CTRL_BITS_EN
    chk("ctrl_bits", ctrl_bits, CTRL_PAT);
`endif

    lock_watch = 1'b1;
    run_frame(0, 99, 1'b0);
    run_frame(0, 99, 1'b0);
    lock_watch = 1'b0;
    chk("b2b_done", n_done, 3);
    chk("b2b_lock_drop", lock_drop, 0);
    chk("b2b_err", n_err, 0);
    chk_time("frame3");

    // Data symbol in marker slot 29
    run_frame(0, 28, 1'b0);
    step(1'b1, S_ONE);
    chk("slot29_err", sync_err, 1);
    chk("slot29_locked", locked, 0);
    step(1'b0, S_ZERO);
    chk("slot29_err_one_cycle", sync_err, 0);
    step(1'b1, S_MARK);
    step(1'b0, S_ZERO);
    step(1'b1, S_MARK);
    chk("resync_ts_reset", ts_reset, 1);
    chk("resync_locked", locked, 1);
    step(1'b0, S_ZERO);

    // Marker at data position 45
    run_frame(1, 44, 1'b0);
    step(1'b1, S_MARK);
    chk("pos45_err", sync_err, 1);
    chk("pos45_locked", locked, 0);
    step(1'b0, S_ZERO);
    run_frame(46, 99, 1'b1);
    chk("pos45_no_done", n_done, 3);
    chk("pos45_err_count", n_err, 2);

    // Stall at pos 50 until timeout
    run_frame(0, 50, 1'b0);
    for (int k = 2; k <= T; k++) begin
      step(1'b0, S_ZERO);
      chk($sformatf("timeout_err[%0d]", k), sync_err, (k == T));
    end
    chk("timeout_locked", locked, 0);
    step(1'b0, S_ZERO);
    chk("timeout_err_one_cycle", sync_err, 0);
    chk("timeout_err_count", n_err, 3);

    // Same stall, but a symbol lands on the terminal cycle
    step(1'b1, S_MARK);
    step(1'b0, S_ZERO);
    run_frame(0, 50, 1'b0);
    for (int k = 2; k <= T - 1; k++) begin
      step(1'b0, S_ZERO);
      chk($sformatf("no_timeout_err[%0d]", k), sync_err, 0);
    end
    step(1'b1, vec[51].sym);
    chk("terminal_sym_err", sync_err, 0);
    chk("terminal_sym_locked", locked, 1);
    chk("terminal_sym_sel", ts_select, 5);
    chk("terminal_sym_bit", bit_idx, 1);
    step(1'b0, S_ZERO);

    // Asynchronous reset mid-frame at pos 70
    run_frame(52, 70, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    @(posedge clk);
    #1 rst = 1'b0;
    run_frame(71, 99, 1'b1);
    chk("rst_no_done", n_done, 3);
    chk("final_err_count", n_err, 3);
    chk("final_reset_count", n_reset, 7);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
